parking_gate_arbiter: RTL and testbench
=======================================

Name: parking_gate_arbiter

Overview:
- Sequences the single physical barrier gate shared by the entry lane and the exit lane of the car park.
- Entry requests come from the entrance password controller once a correct password is accepted. Exit requests come from the exit-lane sensor.
- Arbitrates between the two lanes, drives the barrier motor through a raise/open/lower cycle, and tracks lot occupancy.
- Refuses entry when the lot is full and refuses exit when it is empty.

Parameters:
- CAPACITY, 8, number of parking slots.
- CNT_W, 4, width of occupancy; must hold CAPACITY.
- MOVE_CYCLES, 4, clock cycles the motor runs to raise or to lower the barrier (>=1).
- PASS_TIMEOUT, 16, maximum cycles the barrier stays open waiting for a vehicle (>=1).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- entry_req  in  1  level; entrance controller has accepted a password; held until entry_grant.
- exit_req  in  1  level; vehicle waiting at exit; held until exit_grant.
- pass_sensor  in  1  vehicle has fully passed under the barrier.
- entry_grant  out  1  one-cycle pulse: entry transaction started.
- exit_grant  out  1  one-cycle pulse: exit transaction started.
- motor_up  out  1  raise barrier.
- motor_down  out  1  lower barrier.
- gate_open  out  1  barrier fully up.
- occupancy  out  CNT_W  vehicles currently parked.
- full  out  1  occupancy == CAPACITY.
- empty  out  1  occupancy == 0.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (synchronous, takes effect at the next edge, also mid-operation):
  - State goes to IDLE.
  - Outputs: entry_grant/exit_grant/motor_up/motor_down/gate_open = 0; occupancy = 0; empty = 1; full = 0; busy = 0.
  - Internal state cleared: last_served = EXIT, timers = 0, dir = ENTRY.
- State registers:
  - state: IDLE, RAISE, OPEN, LOWER.
  - dir: direction of the current transaction, ENTRY or EXIT.
- Eligibility, evaluated in IDLE only:
  - ent_ok = entry_req & ~full.
  - ext_ok = exit_req & ~empty.
- IDLE:
  - Neither eligible: stay in IDLE.
  - One eligible: select it.
  - Both eligible: round-robin; pick the lane opposite last_served. First tie after reset goes to ENTRY.
  - On select: next state RAISE; latch dir; update last_served; assert the matching grant for exactly one cycle, coincident with the first RAISE cycle.
  - Requests arriving while busy are not queued. A held level is re-evaluated on return to IDLE.
- RAISE:
  - motor_up = 1 for exactly MOVE_CYCLES cycles, then OPEN.
- OPEN:
  - gate_open = 1; a wait timer counts from 0.
  - pass_sensor = 1 in any OPEN cycle: go to LOWER. At that same edge, occupancy +1 if dir = ENTRY, -1 if dir = EXIT.
  - Timer reaches PASS_TIMEOUT-1 with no pass: go to LOWER; occupancy unchanged.
  - pass_sensor outside OPEN is ignored.
- LOWER:
  - motor_down = 1 for exactly MOVE_CYCLES cycles, then IDLE.
- Latency:
  - Request high in IDLE at edge N gives grant/motor_up high in cycle N+1.
  - gate_open is first high in cycle N+1+MOVE_CYCLES.
- Minimum transaction: 2*MOVE_CYCLES+1 cycles in non-IDLE states, plus one IDLE cycle before the next grant.
- Occupancy: never exceeds CAPACITY and never goes below 0. The update saturates defensively even though eligibility already prevents it.
- Output decoding:
  - motor_up, motor_down, gate_open, grants: registered.
  - full, empty, busy: decoded directly from the state/occupancy registers.
  - motor_up and motor_down are never high together.

Optional Feature:
- Macro: PARK_EXIT_PRIORITY_EN.
- Defined: when both lanes are eligible in IDLE, exit always wins (clears the lot under congestion); last_served is still updated but does not affect the choice.
- Undefined: round-robin as specified above.

Test Plan:
- Single entry:
  - Stimulus: reset, then entry_req=1; pass_sensor pulse on the 3rd OPEN cycle; MOVE_CYCLES=4.
  - Response: entry_grant pulses 1 cycle; motor_up for 4 cycles; gate_open for 3 cycles; motor_down for 4 cycles; occupancy 0->1; empty drops.
- Timeout:
  - Stimulus: entry_req with pass_sensor held 0.
  - Response: gate_open high for exactly 16 cycles, then LOWER; occupancy stays 0.
- Full lot:
  - Stimulus: CAPACITY=2; complete 2 entries, then entry_req=1.
  - Response: full=1; no entry_grant; busy stays 0. A subsequent exit transaction brings occupancy to 1, and the held entry_req is then granted.
- Simultaneous requests:
  - Stimulus: occupancy=3; entry_req and exit_req held continuously.
  - Response: grants alternate ENTRY, EXIT, ENTRY, EXIT. With PARK_EXIT_PRIORITY_EN defined, the grants are EXIT, EXIT, EXIT until empty, then ENTRY.
- Empty exit:
  - Stimulus: after reset, exit_req=1.
  - Response: no exit_grant; state stays IDLE.
- Reset mid-operation:
  - Stimulus: assert reset during the 2nd OPEN cycle with occupancy=1.
  - Response: next cycle gate_open=0, motor_up/motor_down=0, busy=0, occupancy=0.

Source files
------------

// File: rtl/parking_gate_arbiter.sv
// Shared entry/exit barrier sequencer with occupancy tracking.
// Define PARK_EXIT_PRIORITY_EN to let exit always win a tie instead of round-robin.
module parking_gate_arbiter #(
  parameter int CAPACITY     = 8,
  parameter int CNT_W        = 4,
  parameter int MOVE_CYCLES  = 4,
  parameter int PASS_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             entry_req,
  input  logic             exit_req,
  input  logic             pass_sensor,
  output logic             entry_grant,
  output logic             exit_grant,
  output logic             motor_up,
  output logic             motor_down,
  output logic             gate_open,
  output logic [CNT_W-1:0] occupancy,
  output logic             full,
  output logic             empty,
  output logic             busy
);

  localparam int TMAX  = (MOVE_CYCLES > PASS_TIMEOUT) ? MOVE_CYCLES : PASS_TIMEOUT;
  localparam int TMR_W = $clog2(TMAX) + 1;
  localparam logic [TMR_W-1:0] MOVE_LAST = TMR_W'(MOVE_CYCLES - 1);
  localparam logic [TMR_W-1:0] OPEN_LAST = TMR_W'(PASS_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CAP_VAL   = CNT_W'(CAPACITY);

  typedef enum logic [1:0] {IDLE, RAISE, OPEN, LOWER} state_t;
  typedef enum logic {DIR_ENTRY, DIR_EXIT} dir_t;

  state_t             state, state_next;
  dir_t               dir, dir_next, last_served, last_next;
  logic [TMR_W-1:0]   timer, timer_next;
  logic [CNT_W-1:0]   occ_next;
  logic               ent_ok, ext_ok, pick_exit;
  logic               entry_grant_next, exit_grant_next;

  assign full  = (occupancy == CAP_VAL);
  assign empty = (occupancy == '0);
  assign busy  = (state != IDLE);

  always_comb begin
    state_next       = state;
    dir_next         = dir;
    last_next        = last_served;
    timer_next       = timer;
    occ_next         = occupancy;
    entry_grant_next = 1'b0;
    exit_grant_next  = 1'b0;
    ent_ok           = entry_req & ~full;
    ext_ok           = exit_req & ~empty;
    pick_exit        = 1'b0;

    unique case (state)
      IDLE: begin
        timer_next = '0;
        if (ent_ok && ext_ok) begin
`ifdef PARK_EXIT_PRIORITY_EN
          pick_exit = 1'b1;
`else
          pick_exit = (last_served == DIR_ENTRY);
`endif
        end else begin
          pick_exit = ext_ok;
        end
        if (ent_ok || ext_ok) begin
          state_next       = RAISE;
          dir_next         = pick_exit ? DIR_EXIT : DIR_ENTRY;
          last_next        = pick_exit ? DIR_EXIT : DIR_ENTRY;
          entry_grant_next = ~pick_exit;
          exit_grant_next  = pick_exit;
        end
      end
      RAISE: begin
        if (timer == MOVE_LAST) begin
          state_next = OPEN;
          timer_next = '0;
        end else begin
          timer_next = timer + TMR_W'(1);
        end
      end
      OPEN: begin
        // A pass commits the occupancy change; saturation guards against
        // any path that slips past the eligibility check.
        if (pass_sensor) begin
          state_next = LOWER;
          timer_next = '0;
          if (dir == DIR_ENTRY) begin
            if (occupancy != CAP_VAL) occ_next = occupancy + CNT_W'(1);
          end else begin
            if (occupancy != '0) occ_next = occupancy - CNT_W'(1);
          end
        end else if (timer == OPEN_LAST) begin
          state_next = LOWER;
          timer_next = '0;
        end else begin
          timer_next = timer + TMR_W'(1);
        end
      end
      LOWER: begin
        if (timer == MOVE_LAST) begin
          state_next = IDLE;
          timer_next = '0;
        end else begin
          timer_next = timer + TMR_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Motor/gate outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      dir         <= DIR_ENTRY;
      last_served <= DIR_EXIT;
      timer       <= '0;
      occupancy   <= '0;
      entry_grant <= 1'b0;
      exit_grant  <= 1'b0;
      motor_up    <= 1'b0;
      motor_down  <= 1'b0;
      gate_open   <= 1'b0;
    end else begin
      state       <= state_next;
      dir         <= dir_next;
      last_served <= last_next;
      timer       <= timer_next;
      occupancy   <= occ_next;
      entry_grant <= entry_grant_next;
      exit_grant  <= exit_grant_next;
      motor_up    <= (state_next == RAISE);
      motor_down  <= (state_next == LOWER);
      gate_open   <= (state_next == OPEN);
    end
  end

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Directed bench for parking_gate_arbiter (CAPACITY overridden to 4, other parameters default).
module tb_parking_gate_arbiter;

  logic       clk = 1'b0;
  logic       reset, entry_req, exit_req, pass_sensor;
  logic       entry_grant, exit_grant, motor_up, motor_down, gate_open;
  logic [3:0] occupancy;
  logic       full, empty, busy;

  int total = 0;
  int bad   = 0;

  parking_gate_arbiter #(.CAPACITY(4), .CNT_W(4), .MOVE_CYCLES(4), .PASS_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .entry_req(entry_req), .exit_req(exit_req),
    .pass_sensor(pass_sensor), .entry_grant(entry_grant), .exit_grant(exit_grant),
    .motor_up(motor_up), .motor_down(motor_down), .gate_open(gate_open),
    .occupancy(occupancy), .full(full), .empty(empty), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One full transaction: request, grant, raise, open (pass on cycle pass_at, 0 = never), lower.
  task automatic run_txn(input string tag, input bit is_exit, input int pass_at,
                         input int exp_open, input int exp_occ);
    int n;
    bit got;
    got = 1'b0;
    if (is_exit) exit_req = 1'b1; else entry_req = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      got = entry_grant | exit_grant;
    end
    check_output({tag, "_grant"}, is_exit ? exit_grant : entry_grant, 1);
    check_output({tag, "_other_grant"}, is_exit ? entry_grant : exit_grant, 0);
    if (is_exit) exit_req = 1'b0; else entry_req = 1'b0;
    n = 0;
    while (motor_up && n < 50) begin n++; tick(); end
    check_output({tag, "_up_cycles"}, n, 4);
    n = 0;
    while (gate_open && n < 50) begin
      n++;
      pass_sensor = (n == pass_at);
      tick();
      pass_sensor = 1'b0;
    end
    check_output({tag, "_open_cycles"}, n, exp_open);
    n = 0;
    while (motor_down && n < 50) begin n++; tick(); end
    check_output({tag, "_down_cycles"}, n, 4);
    check_output({tag, "_busy_end"}, busy, 0);
    check_output({tag, "_occ"}, occupancy, exp_occ);
  endtask

  initial begin
    bit seen;
    bit got;
    int n;
    logic [3:0] grant_exit_seq;
    logic [3:0] exp_seq;
    reset = 1'b1; entry_req = 1'b0; exit_req = 1'b0; pass_sensor = 1'b0;
    @(negedge clk);
    tick(); tick();
    check_output("rst_busy", busy, 0);
    check_output("rst_empty", empty, 1);
    check_output("rst_full", full, 0);
    check_output("rst_occ", occupancy, 0);
    check_output("rst_outs", {entry_grant, exit_grant, motor_up, motor_down, gate_open}, 0);
    reset = 1'b0;

    // Exit from an empty lot is refused.
    exit_req = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin tick(); seen |= exit_grant | busy; end
    check_output("empty_exit_refused", seen, 0);
    exit_req = 1'b0;
    tick();

    run_txn("single_entry", 1'b0, 3, 3, 1);
    check_output("single_entry_empty", empty, 0);
    run_txn("timeout", 1'b0, 0, 16, 1);
    run_txn("fill2", 1'b0, 1, 1, 2);
    run_txn("fill3", 1'b0, 1, 1, 3);
    run_txn("fill4", 1'b0, 1, 1, 4);
    check_output("full_flag", full, 1);

    // Entry on a full lot stays pending and is served once an exit frees a slot.
    entry_req = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin tick(); seen |= entry_grant | busy; end
    check_output("full_entry_refused", seen, 0);
    run_txn("exit_from_full", 1'b1, 1, 1, 3);
    check_output("not_full", full, 0);
    run_txn("held_entry", 1'b0, 1, 1, 4);
    run_txn("exit_to3", 1'b1, 2, 2, 3);

    // Both lanes held continuously; record which lane wins each grant.
`ifdef PARK_EXIT_PRIORITY_EN
    exp_seq = 4'b0111;
`else
    exp_seq = 4'b1010;
`endif
    grant_exit_seq = 4'b0;
    entry_req = 1'b1; exit_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
        tick();
        got = entry_grant | exit_grant;
      end
      check_output($sformatf("tie_grant_%0d", k), got, 1);
      grant_exit_seq[k] = exit_grant;
      n = 0;
      while (busy && n < 100) begin
        pass_sensor = gate_open;
        tick();
        n++;
      end
      pass_sensor = 1'b0;
    end
    entry_req = 1'b0; exit_req = 1'b0;
    check_output("tie_order", grant_exit_seq, exp_seq);
`ifdef PARK_EXIT_PRIORITY_EN
    check_output("tie_occ", occupancy, 1);
`else
    check_output("tie_occ", occupancy, 3);
`endif
    tick();

    // Reset during the 2nd OPEN cycle clears everything at the next edge.
    entry_req = 1'b1;
    n = 0;
    while (!gate_open && n < 30) begin tick(); n++; end
    entry_req = 1'b0;
    check_output("mid_reached_open", gate_open, 1);
    tick();
    check_output("mid_open2", gate_open, 1);
    reset = 1'b1;
    tick();
    check_output("mid_rst_outs", {motor_up, motor_down, gate_open, entry_grant, exit_grant}, 0);
    check_output("mid_rst_busy", busy, 0);
    check_output("mid_rst_occ", occupancy, 0);
    check_output("mid_rst_empty", empty, 1);
    reset = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
